// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache between the CPU word port and the 256-bit line port.
// Latency: a hit responds combinationally in the same cycle; a miss waits on writeback (if dirty) and fill, then hits.
// Backpressure: CPU request is held until mem_resp; pmem_read/pmem_write are held until pmem_resp.
module dm_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int NSETS = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;

  // Per-set metadata and line storage.
  logic [NSETS-1:0] valid_q;
  logic [NSETS-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [NSETS];
  logic [255:0]     data_q [NSETS];

  // Line address of the miss being serviced. Latched on miss entry so the
  // memory-side address stays stable even if the CPU drops its request.
  logic [26:0] miss_line_q, miss_line_d;

  logic [S_INDEX-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [2:0]         cpu_word;
  logic [S_INDEX-1:0] miss_idx;
  logic [TAG_W-1:0]   miss_tag;
  logic               hit;
  logic               req;
  logic               hit_wr;
  logic               wb_done;
  logic               fill_done;
  logic               unused_addr_bits;

  assign cpu_word = mem_address[4:2];
  assign cpu_idx  = mem_address[4+S_INDEX:5];
  assign cpu_tag  = mem_address[31:5+S_INDEX];
  assign miss_idx = miss_line_q[S_INDEX-1:0];
  assign miss_tag = miss_line_q[26:S_INDEX];

  // Byte offset within a word never affects word selection.
  assign unused_addr_bits = &{1'b0, mem_address[1:0]};

  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign req       = mem_read | mem_write;
  assign mem_rdata = data_q[cpu_idx][{cpu_word, 5'b00000} +: 32];

  // Next-state and output decode; all outputs default to inactive/zero.
  always_comb begin
    state_d      = state_q;
    miss_line_d  = miss_line_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    hit_wr       = 1'b0;
    wb_done      = 1'b0;
    fill_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            // A simultaneous read and write is serviced as a write.
            hit_wr   = mem_write;
          end else begin
            miss_line_d = mem_address[31:5];
            state_d     = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx], miss_idx, 5'b00000};
        pmem_wdata   = data_q[miss_idx];
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_line_q, 5'b00000};
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and valid/dirty bits; reset abandons any in-flight fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      if (hit_wr) begin
        dirty_q[cpu_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[miss_idx] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Line data and tags: byte-lane merge on hit writes, whole-line install on fill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byte_enable[b]) begin
            data_q[cpu_idx][{cpu_word, 2'(b), 3'b000} +: 8] <= mem_wdata[8*b +: 8];
          end
        end
      end
      if (fill_done) begin
        data_q[miss_idx] <= pmem_rdata;
        tag_q[miss_idx]  <= miss_tag;
      end
    end
  end

endmodule
